// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared definitions for the intersection controller
// Purpose: phase-timer state encoding, light codes and the default tick
//          divider, shared by the phase timer and the light-sequencing FSM.
// Ports:   none (package).
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPIRE = 2'd1,
    ARM    = 2'd2,
    RUN    = 2'd3
  } phase_state_t;

  localparam logic [1:0] OFF    = 2'd0;
  localparam logic [1:0] RED    = 2'd1;
  localparam logic [1:0] YELLOW = 2'd2;
  localparam logic [1:0] GREEN  = 2'd3;

  // Clock cycles per second at the 10 kHz system clock.
  localparam int DEFAULT_TICK_DIV = 10000;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - one-second prescaler for the phase timer
// Purpose: counts 0..TICK_DIV-1 while run is high and wraps.
// Ports:   clk   - system clock
//          reset - synchronous, active-high
//          clear - forces the count to 0 and drops tick
//          run   - advance the count this cycle
//          tick  - registered; high for the cycle in which count == TICK_DIV-1
module tick_gen
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST     = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 2);

  logic [PW-1:0] count;

  // tick is raised one edge early (at PRE_LAST) so that it is a register
  // yet coincides exactly with the cycle holding the terminal count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + PW'(1);
      tick  <= (count == PRE_LAST);
    end else begin
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-phase duration timer for the light sequencer
// Purpose: loads the phase duration from the sequencing FSM, counts whole
//          seconds and strobes finished to advance the FSM.
// Ports:   clk        - system clock, 10 kHz
//          reset      - synchronous, active-high
//          enable     - system enable; low = lights off, timer idles
//          abort      - sensor-driven early end of the running phase
//          seconds_in - phase duration, sampled only in ARM
//          finished   - 1-cycle strobe, FSM may advance
//          busy       - high in ARM or RUN
//          remaining  - whole seconds left in the current phase
//          tick_1s    - 1-cycle pulse at each second boundary in RUN
module phase_timer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int SEC_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             abort,
  input  logic [SEC_W-1:0] seconds_in,
  output logic             finished,
  output logic             busy,
  output logic [SEC_W-1:0] remaining,
  output logic             tick_1s
);

  phase_state_t state, state_next;
  logic         finished_next, busy_next;
  logic         tick, gen_clear, gen_run;

  // The prescaler only advances in RUN; leaving RUN for any reason
  // (abort, disable, expiry) restarts the next phase from count 0.
  assign gen_run   = (state == RUN);
  assign gen_clear = !enable || abort || (state != RUN);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (gen_clear),
    .run   (gen_run),
    .tick  (tick)
  );

  assign tick_1s = tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      finished <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      finished <= finished_next;
      busy     <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:   state_next = EXPIRE;
        EXPIRE: state_next = ARM;
        ARM:    state_next = (seconds_in == '0) ? EXPIRE : RUN;
        RUN: begin
          if (abort)
            state_next = EXPIRE;
          else if (tick && remaining <= SEC_W'(1))
            state_next = EXPIRE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they are
  // valid in the same cycle the state register holds that state.
  always_comb begin
    finished_next = (state_next == EXPIRE);
    busy_next     = (state_next == ARM) || (state_next == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      remaining <= '0;
    end else if (state == ARM) begin
      remaining <= seconds_in;
    end else if (state == RUN) begin
      if (abort)
        remaining <= '0;
      else if (tick && remaining != '0)
        remaining <= remaining - SEC_W'(1);
    end
  end

endmodule

// File: tb/tb_phase_timer.sv
// tb/tb_phase_timer.sv - self-checking bench for phase_timer
module tb_phase_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] seconds_in = 16'd0;
  logic        finished, busy, tick_1s;
  logic [15:0] remaining;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  phase_timer #(.TICK_DIV(4), .SEC_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .abort      (abort),
    .seconds_in (seconds_in),
    .finished   (finished),
    .busy       (busy),
    .remaining  (remaining),
    .tick_1s    (tick_1s)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        ab;
    logic [15:0] sec;
    logic        fin;
    logic        bsy;
    logic [15:0] rem;
    logic        tck;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic rst, en, ab, input logic [15:0] sec,
                              input logic fin, bsy, input logic [15:0] rem,
                              input logic tck);
    vec_t v;
    v.rst = rst; v.en = en; v.ab = ab; v.sec = sec;
    v.fin = fin; v.bsy = bsy; v.rem = rem; v.tck = tck;
    return v;
  endfunction

  // Inputs are held for one full cycle; outputs are sampled 1 time unit
  // after the closing edge.
  task automatic step(input logic rst, en, ab, input logic [15:0] sec);
    @(negedge clk);
    reset = rst; enable = en; abort = ab; seconds_in = sec;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic fin, bsy,
                     input logic [15:0] rem, input logic tck);
    n_vec++;
    if (finished !== fin || busy !== bsy || remaining !== rem || tick_1s !== tck) begin
      n_err++;
      $display("FAIL %s: got fin=%0b busy=%0b rem=%0d tick=%0b, want fin=%0b busy=%0b rem=%0d tick=%0b",
               name, finished, busy, remaining, tick_1s, fin, bsy, rem, tck);
    end
  endtask

  // Reset, enable, pass EXPIRE and ARM; returns observing the first RUN cycle.
  task automatic start_run(input logic [15:0] n);
    step(1'b1, 1'b1, 1'b0, n);
    step(1'b0, 1'b1, 1'b0, n);
    step(1'b0, 1'b1, 1'b0, n);
    step(1'b0, 1'b1, 1'b0, n);
  endtask

  initial begin
    //             rst en ab sec     fin bsy rem tick
    tbl[0]  = mk(1, 1, 0, 16'd3,   0, 0, 16'd0, 0);
    tbl[1]  = mk(0, 1, 0, 16'd3,   1, 0, 16'd0, 0);
    tbl[2]  = mk(0, 1, 0, 16'd3,   0, 1, 16'd0, 0);
    tbl[3]  = mk(0, 1, 0, 16'd3,   0, 1, 16'd3, 0);
    tbl[4]  = mk(0, 1, 0, 16'd7,   0, 1, 16'd3, 0);
    tbl[5]  = mk(0, 1, 0, 16'd7,   0, 1, 16'd3, 0);
    tbl[6]  = mk(0, 1, 0, 16'd7,   0, 1, 16'd3, 1);
    tbl[7]  = mk(0, 1, 0, 16'd7,   0, 1, 16'd2, 0);
    tbl[8]  = mk(0, 1, 0, 16'd7,   0, 1, 16'd2, 0);
    tbl[9]  = mk(0, 1, 0, 16'd7,   0, 1, 16'd2, 0);
    tbl[10] = mk(0, 1, 0, 16'd7,   0, 1, 16'd2, 1);
    tbl[11] = mk(0, 1, 0, 16'd7,   0, 1, 16'd1, 0);
    tbl[12] = mk(0, 1, 0, 16'd7,   0, 1, 16'd1, 0);
    tbl[13] = mk(0, 1, 0, 16'd7,   0, 1, 16'd1, 0);
    tbl[14] = mk(0, 1, 0, 16'd7,   0, 1, 16'd1, 1);
    tbl[15] = mk(0, 1, 0, 16'd0,   1, 0, 16'd0, 0);
    tbl[16] = mk(0, 1, 0, 16'd0,   0, 1, 16'd0, 0);
    tbl[17] = mk(0, 1, 0, 16'd0,   1, 0, 16'd0, 0);
    tbl[18] = mk(0, 1, 0, 16'd2,   0, 1, 16'd0, 0);
    tbl[19] = mk(0, 1, 0, 16'd2,   0, 1, 16'd2, 0);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].ab, tbl[i].sec);
      chk($sformatf("vec%0d", i), tbl[i].fin, tbl[i].bsy, tbl[i].rem, tbl[i].tck);
    end

    // abort in the 6th RUN cycle, then abort ignored in EXPIRE and ARM
    start_run(16'd5);
    chk("abort_run1", 1'b0, 1'b1, 16'd5, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 16'd9);
    chk("abort_pre", 1'b0, 1'b1, 16'd4, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'd2);
    chk("abort_fin", 1'b1, 1'b0, 16'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'd2);
    chk("abort_in_expire", 1'b0, 1'b1, 16'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'd2);
    chk("abort_in_arm", 1'b0, 1'b1, 16'd2, 1'b0);

    // enable dropped mid-RUN, then raised again
    start_run(16'd5);
    repeat (2) step(1'b0, 1'b1, 1'b0, 16'd5);
    chk("en_mid", 1'b0, 1'b1, 16'd5, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'd5);
    chk("en_off", 1'b0, 1'b0, 16'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'd5);
    chk("en_off_hold", 1'b0, 1'b0, 16'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'd5);
    chk("en_restart", 1'b1, 1'b0, 16'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'd5);
    chk("en_restart_arm", 1'b0, 1'b1, 16'd0, 1'b0);

    // enable low overrides abort and a wrap in the same cycle
    start_run(16'd5);
    repeat (3) step(1'b0, 1'b1, 1'b0, 16'd5);
    chk("wrap_pre", 1'b0, 1'b1, 16'd5, 1'b1);
    step(1'b0, 1'b0, 1'b1, 16'd5);
    chk("en_off_wrap", 1'b0, 1'b0, 16'd0, 1'b0);

    // reset during a prescaler wrap
    start_run(16'd5);
    repeat (3) step(1'b0, 1'b1, 1'b0, 16'd5);
    chk("rst_wrap_pre", 1'b0, 1'b1, 16'd5, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'd5);
    chk("rst_wrap", 1'b0, 1'b0, 16'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'd5);
    chk("rst_after1", 1'b0, 1'b0, 16'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'd5);
    chk("rst_after2", 1'b0, 1'b0, 16'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
